histogram_loader: RTL and testbench
===================================

# histogram_loader

Restores a saved 1024-word histogram from the SD card into histogram RAM. It is the read-back counterpart of the histogram save path and sits between the SD card controller's read port and the write port of the histogram block RAM. A slot holds 2048 bytes in four consecutive 512-byte sectors starting at byte address slot×2048, with each 16-bit word stored MS byte first.

## Interface
Parameters:
- SECTORS, 4: sectors per slot; fixed by the slot layout.
- SECTOR_BYTES, 512: bytes per SD sector.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin a load; sampled only in STANDBY.
- slot  input  7  slot index; latched on start.
- sd_ready  input  1  SD controller idle/ready.
- sd_address  output  32  sector byte address to the SD controller.
- sd_rd  output  1  read request to the SD controller.
- sd_dout  input  8  read byte from the SD controller.
- sd_byte_available  input  1  level; a rising edge marks a new valid sd_dout.
- waddr  output  10  histogram RAM word address.
- wdata  output  16  histogram RAM write data.
- we  output  1  histogram RAM write enable; one-cycle pulse per word.
- loading  output  1  high from start acceptance until the load ends.
- done  output  1  one-cycle pulse when the load ends.
- error  output  1  sticky short/long-sector flag; cleared on the next accepted start.
- checksum  output  16  running word sum (see Configuration).

## Operation
- States:
  - STANDBY: loading=0. On start:
    - latch sd_address={slot,11'b0} (zero-extended to 32 bits);
    - clear sector, byte count, error and checksum;
    - set loading=1 and go to INIT.
  - INIT: wait for sd_ready=1, then assert sd_rd=1 and go to ARM.
  - ARM: wait for sd_ready=0, then set sd_rd=0 and go to LOAD.
  - LOAD:
    - On the cycle where sd_byte_available=1 and its registered previous value is 0:
      - even byte count: capture sd_dout into the MS holding register;
      - odd byte count: issue a word write with wdata={ms, sd_dout} and waddr={sector[1:0], bytecnt[8:1]};
      - byte count increments in both cases.
    - When sd_ready=1:
      - if byte count≠512, set error=1;
      - if sector=3, go to STANDBY and pulse done;
      - otherwise increment sector, add 512 to sd_address, clear byte count and go to INIT.
- Byte count is 10 bits. Bytes at count ≥512 produce no writes, do not wrap into the next sector's addresses, and cause error at sector end.
- A short sector leaves its remaining RAM words unwritten.
- start while loading=1 is ignored.
- If an edge and sd_ready=1 occur in the same LOAD cycle, the byte is accepted first, then sector end is evaluated with the updated count.

## Timing
- Reset values: sd_rd=0, we=0, loading=0, done=0, error=0, checksum=0, waddr=0, wdata=0, sd_address=0. State returns to STANDBY.
- Reset mid-load aborts immediately and holds sd_rd=0. RAM keeps any words already written.
- start accepted in cycle N gives loading=1 in cycle N+1.
- sd_rd rises the cycle after INIT sees sd_ready and stays high until the cycle after sd_ready falls.
- The write is registered: we, waddr and wdata are valid in the cycle after the LS-byte edge-detect cycle, and we is high for exactly 1 cycle.
- done pulses the cycle after the final sd_ready is seen in sector 3. loading falls in that same cycle, and the final we is not later than done.
- Best case is 2 cycles between byte edges. The block sustains one word per 2 byte edges with no backpressure.

## Configuration
- HISTOGRAM_LOADER_CHECKSUM_EN:
  - Defined: checksum accumulates the 16-bit sum (mod 2^16) of every written wdata and updates in the same cycle as we. It is valid at done and held until the next start.
  - Undefined: checksum is tied to 16'h0000 and the adder is not built.

## Test plan
- Slot 3, model returns bytes k[7:0] for byte k in each sector -> sd_address is 0x1800, 0x1A00, 0x1C00, 0x1E00; 1024 we pulses; word at waddr 0x105 is 16'h0A0B; done once; error=0.
- Sector 1 ends after 510 bytes -> error=1, RAM words 0x1FF of sector 1 (waddr 0x1FF) unwritten, load completes, done pulses.
- Sector 0 delivers 514 bytes -> exactly 256 writes for sector 0, first sector-1 write at waddr 0x100, error=1.
- reset asserted during sector 2 -> next cycle loading=0, sd_rd=0, we=0; a subsequent start of slot 0 completes normally with error=0.
- start pulsed during LOAD, and an edge coincident with sd_ready=1 on byte 512 -> start ignored; final word written; no error.
- With HISTOGRAM_LOADER_CHECKSUM_EN, all words 16'h0001 -> checksum=16'h0400 at done. Without the macro -> checksum=0.

Source files
------------

// File: rtl/histogram_loader.sv
// histogram_loader
// Restores a saved 1024-word histogram slot from the SD card into histogram RAM.
// A slot is four 512-byte sectors at byte address slot*2048. Each word is stored
// MS byte first. Every pair of received bytes becomes one registered RAM write.
// Optional feature: define HISTOGRAM_LOADER_CHECKSUM_EN to build a running 16-bit
// sum of the written words. Without it, checksum is tied to zero.
module histogram_loader #(
    parameter int SECTORS      = 4,
    parameter int SECTOR_BYTES = 512
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [6:0]  slot,
    input  logic        sd_ready,
    output logic [31:0] sd_address,
    output logic        sd_rd,
    input  logic [7:0]  sd_dout,
    input  logic        sd_byte_available,
    output logic [9:0]  waddr,
    output logic [15:0] wdata,
    output logic        we,
    output logic        loading,
    output logic        done,
    output logic        error,
    output logic [15:0] checksum
);

    localparam logic [9:0]  BYTE_LIMIT  = 10'(SECTOR_BYTES);
    localparam logic [1:0]  LAST_SECTOR = 2'(SECTORS - 1);
    localparam logic [31:0] SECTOR_STEP = 32'(SECTOR_BYTES);
    localparam logic [9:0]  COUNT_MAX   = 10'h3FF;

    typedef enum logic [1:0] {
        STANDBY = 2'd0,
        INIT    = 2'd1,
        ARM     = 2'd2,
        LOAD    = 2'd3
    } state_t;

    state_t      state;
    logic [1:0]  sector;
    logic [9:0]  byte_count;
    logic [7:0]  ms_byte;
    logic        avail_prev;

    logic        byte_edge;
    logic        load_edge;
    logic        byte_in_range;
    logic        write_fire;
    logic        start_accept;
    logic [9:0]  count_after;

    // Byte counter advance. It saturates so that an over-long sector can never
    // wrap back below the limit and overwrite words of the same sector.
    function automatic logic [9:0] bump_count(input logic [9:0] cnt, input logic inc);
        if (inc && (cnt != COUNT_MAX)) begin
            return cnt + 10'd1;
        end
        return cnt;
    endfunction

    // A new byte is a rising edge of the availability level.
    assign byte_edge     = sd_byte_available & ~avail_prev;
    assign load_edge     = (state == LOAD) & byte_edge;
    assign byte_in_range = (byte_count < BYTE_LIMIT);
    assign write_fire    = load_edge & byte_count[0] & byte_in_range;
    assign start_accept  = (state == STANDBY) & start;
    // The sector-end test uses the count after the byte accepted in this cycle.
    assign count_after   = bump_count(byte_count, load_edge);

    // Load sequencer: SD read handshake, byte pairing and registered RAM writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= STANDBY;
            sd_rd      <= 1'b0;
            we         <= 1'b0;
            loading    <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            waddr      <= '0;
            wdata      <= '0;
            sd_address <= '0;
            sector     <= '0;
            byte_count <= '0;
            ms_byte    <= '0;
            avail_prev <= 1'b0;
        end else begin
            avail_prev <= sd_byte_available;
            we         <= 1'b0;
            done       <= 1'b0;

            case (state)
                STANDBY: begin
                    if (start) begin
                        sd_address <= {14'b0, slot, 11'b0};
                        sector     <= '0;
                        byte_count <= '0;
                        error      <= 1'b0;
                        loading    <= 1'b1;
                        state      <= INIT;
                    end
                end

                INIT: begin
                    if (sd_ready) begin
                        sd_rd <= 1'b1;
                        state <= ARM;
                    end
                end

                ARM: begin
                    // The controller drops ready once it has taken the request.
                    if (!sd_ready) begin
                        sd_rd <= 1'b0;
                        state <= LOAD;
                    end
                end

                LOAD: begin
                    if (byte_edge) begin
                        byte_count <= count_after;
                        if (!byte_count[0]) begin
                            ms_byte <= sd_dout;
                        end
                    end
                    if (write_fire) begin
                        we    <= 1'b1;
                        waddr <= {sector, byte_count[8:1]};
                        wdata <= {ms_byte, sd_dout};
                    end
                    if (sd_ready) begin
                        if (count_after != BYTE_LIMIT) begin
                            error <= 1'b1;
                        end
                        if (sector == LAST_SECTOR) begin
                            loading <= 1'b0;
                            done    <= 1'b1;
                            state   <= STANDBY;
                        end else begin
                            sector     <= sector + 2'd1;
                            sd_address <= sd_address + SECTOR_STEP;
                            byte_count <= '0;
                            state      <= INIT;
                        end
                    end
                end

                default: begin
                    state <= STANDBY;
                end
            endcase
        end
    end

`ifdef HISTOGRAM_LOADER_CHECKSUM_EN
    logic [15:0] sum_q;

    // Running word sum; it moves in the same cycle as we and holds after done.
    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q <= '0;
        end else if (start_accept) begin
            sum_q <= '0;
        end else if (write_fire) begin
            sum_q <= sum_q + {ms_byte, sd_dout};
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_histogram_loader.sv
// Testbench for histogram_loader: an SD controller model feeds sectors, a RAM
// model records writes, and a reference built from the slot layout rules predicts
// RAM contents, write counts, error and checksum.
module tb_histogram_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [6:0]  slot;
    logic        sd_ready;
    logic [31:0] sd_address;
    logic        sd_rd;
    logic [7:0]  sd_dout;
    logic        sd_byte_available;
    logic [9:0]  waddr;
    logic [15:0] wdata;
    logic        we;
    logic        loading;
    logic        done;
    logic        error;
    logic [15:0] checksum;

    always #5 clk = ~clk;

    histogram_loader dut (
        .clk(clk), .reset(reset), .start(start), .slot(slot),
        .sd_ready(sd_ready), .sd_address(sd_address), .sd_rd(sd_rd),
        .sd_dout(sd_dout), .sd_byte_available(sd_byte_available),
        .waddr(waddr), .wdata(wdata), .we(we), .loading(loading),
        .done(done), .error(error), .checksum(checksum)
    );

    int tests = 0;
    int fails = 0;

    // observed
    int          cyc;
    logic [15:0] mem [1024];
    int          wr_hits [1024];
    logic [9:0]  wr_log [$];
    int          done_cnt, done_cyc, last_we_cyc;
    logic        done_loading;

    // reference
    logic [15:0] exp_mem [1024];
    bit          exp_wr [1024];
    int          exp_wcnt;
    logic [15:0] exp_sum;
    bit          exp_err;
    logic [7:0]  cur [1024];

    // stimulus knobs
    int sec_len [4];
    int data_mode;
    bit coinc;
    int abort_sec;
    int poke_sec;
    bit aborted;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (we) begin
            wr_log.push_back(waddr);
            mem[waddr] = wdata;
            wr_hits[waddr]++;
            last_we_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            done_loading = loading;
        end
    endtask

    task automatic clear_log();
        for (int a = 0; a < 1024; a++) begin
            mem[a] = 16'h0; wr_hits[a] = 0; exp_mem[a] = 16'h0; exp_wr[a] = 1'b0;
        end
        wr_log.delete();
        done_cnt = 0; done_cyc = 0; last_we_cyc = 0; done_loading = 1'b1;
        exp_wcnt = 0; exp_sum = 16'h0; exp_err = 1'b0;
    endtask

    function automatic logic [7:0] gen_byte(input int k);
        case (data_mode)
            1:       return k[7:0];
            2:       return (k % 2 == 1) ? 8'h01 : 8'h00;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic run_load(input logic [6:0] s);
        int n;
        int a;
        bit last;
        aborted = 1'b0;
        clear_log();
        start = 1'b1; slot = s;
        tick();
        start = 1'b0; slot = 7'($urandom);
        chk("loading_rise", 32'(loading), 32'd1);
        chk("error_clear", 32'(error), 32'd0);
        for (int sec = 0; sec < 4; sec++) begin
            for (int i = 0; i < 20 && !sd_rd; i++) tick();
            chk("sd_rd_rise", 32'(sd_rd), 32'd1);
            chk("sd_address", sd_address, {14'b0, s, 11'b0} + 32'(sec * 512));
            tick();
            chk("sd_rd_hold", 32'(sd_rd), 32'd1);
            sd_ready = 1'b0;
            tick();
            chk("sd_rd_fall", 32'(sd_rd), 32'd0);
            n = sec_len[sec];
            exp_err |= (n != 512);
            for (int k = 0; k < n; k++) begin
                cur[k] = gen_byte(k);
                if ((k % 2 == 1) && (k < 512)) begin
                    a = sec * 256 + k / 2;
                    exp_mem[a] = {cur[k-1], cur[k]};
                    exp_wr[a] = 1'b1;
                    exp_wcnt++;
                    exp_sum += {cur[k-1], cur[k]};
                end
                last = (k == n - 1);
                sd_dout = cur[k];
                sd_byte_available = 1'b1;
                if (last && coinc) sd_ready = 1'b1;
                if (sec == poke_sec && k == 100) begin
                    start = 1'b1; slot = ~s;
                end
                tick();
                start = 1'b0;
                sd_byte_available = 1'b0;
                if (sec == abort_sec && k == 200) begin
                    reset = 1'b1;
                    tick();
                    chk("abort_loading", 32'(loading), 32'd0);
                    chk("abort_sd_rd", 32'(sd_rd), 32'd0);
                    chk("abort_we", 32'(we), 32'd0);
                    reset = 1'b0;
                    sd_ready = 1'b1;
                    aborted = 1'b1;
                    return;
                end
                if (!(last && coinc)) repeat ($urandom_range(1, 2)) tick();
            end
            if (!coinc) begin
                sd_ready = 1'b1;
                tick();
            end
        end
        for (int i = 0; i < 10 && done_cnt == 0; i++) tick();
        repeat (3) tick();
    endtask

    task automatic verify(input string t);
        int mism;
        int dup;
        logic [15:0] exp_ck;
        mism = 0; dup = 0;
        for (int a = 0; a < 1024; a++) begin
            if (exp_wr[a] != (wr_hits[a] != 0)) mism++;
            else if (exp_wr[a] && mem[a] !== exp_mem[a]) mism++;
            if (wr_hits[a] > 1) dup++;
        end
`ifdef HISTOGRAM_LOADER_CHECKSUM_EN
        exp_ck = exp_sum;
`else
        exp_ck = 16'h0000;
`endif
        chk({t, "_done_count"}, 32'(done_cnt), 32'd1);
        chk({t, "_loading_at_done"}, 32'(done_loading), 32'd0);
        chk({t, "_error"}, 32'(error), 32'(exp_err));
        chk({t, "_we_count"}, 32'(wr_log.size()), 32'(exp_wcnt));
        chk({t, "_ram"}, 32'(mism), 32'd0);
        chk({t, "_dup_writes"}, 32'(dup), 32'd0);
        chk({t, "_we_not_after_done"}, 32'(last_we_cyc <= done_cyc), 32'd1);
        chk({t, "_checksum"}, 32'(checksum), 32'(exp_ck));
    endtask

    initial begin
        int lo;
        cyc = 0;
        reset = 1'b1; start = 1'b0; slot = 7'd0; sd_ready = 1'b1;
        sd_dout = 8'h0; sd_byte_available = 1'b0;
        coinc = 1'b0; abort_sec = -1; poke_sec = -1; data_mode = 0;
        for (int i = 0; i < 4; i++) sec_len[i] = 512;
        clear_log();
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_ctrl", {27'b0, sd_rd, we, loading, done, error}, 32'd0);
        chk("rst_sd_address", sd_address, 32'd0);
        chk("rst_waddr", 32'(waddr), 32'd0);
        chk("rst_wdata", 32'(wdata), 32'd0);
        chk("rst_checksum", 32'(checksum), 32'd0);

        // slot 3, byte k of each sector is k[7:0]
        data_mode = 1;
        run_load(7'd3);
        verify("t1");
        chk("t1_we_1024", 32'(wr_log.size()), 32'd1024);
        chk("t1_word_105", 32'(mem[10'h105]), 32'h0A0B);

        // short sector 1
        data_mode = 0;
        sec_len[1] = 510;
        run_load(7'($urandom));
        verify("t2");
        chk("t2_1ff_unwritten", 32'(wr_hits[10'h1FF]), 32'd0);
        chk("t2_error_set", 32'(error), 32'd1);
        sec_len[1] = 512;

        // long sector 0
        sec_len[0] = 514;
        run_load(7'($urandom));
        verify("t3");
        lo = 0;
        for (int a = 0; a < 256; a++) lo += wr_hits[a];
        chk("t3_sector0_writes", 32'(lo), 32'd256);
        chk("t3_first_s1_waddr", (wr_log.size() > 256) ? 32'(wr_log[256]) : 32'hFFFF, 32'h100);
        sec_len[0] = 512;

        // reset in sector 2, then a clean load of slot 0
        abort_sec = 2;
        run_load(7'($urandom));
        chk("t4_aborted", 32'(aborted), 32'd1);
        abort_sec = -1;
        repeat (3) tick();
        run_load(7'd0);
        verify("t4");

        // start poked mid-load; last byte edge coincides with sd_ready
        coinc = 1'b1; poke_sec = 1;
        run_load(7'($urandom));
        verify("t5");
        coinc = 1'b0; poke_sec = -1;

        // every word 16'h0001
        data_mode = 2;
        run_load(7'($urandom));
        verify("t6");
`ifdef HISTOGRAM_LOADER_CHECKSUM_EN
        chk("t6_checksum_400", 32'(checksum), 32'h0400);
`else
        chk("t6_checksum_zero", 32'(checksum), 32'h0000);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
